tpum_apb_master: RTL and testbench

APB initiator that drives the triple-PUM register file from the host/RISC side. It accepts one command at a time (start address, direction, word count), performs that many back-to-back APB transfers at consecutive word addresses, and streams write data in and read data out over valid/ready interfaces. It is the other end of the TPUM APB slave port, and is used to load control registers and R1/R2/RA vectors, then poll the done register (index 9, address 0x24).

---
 rtl/tpum_apb_master.sv | 183 ++++++++++++++++++
 tb/tb_tpum_apb_master.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpum_apb_master.sv
// tpum_apb_master
//   APB initiator for the triple-PUM register file. Accepts one command at a
//   time (start address, direction, word count) and issues that many
//   back-to-back APB transfers at consecutive word addresses. Write data
//   arrives on a valid/ready stream; read data leaves on a valid/ready stream.
//
// Ports
//   clk, rst_n                        clock, async active-low reset
//   cmd_valid/cmd_ready               command handshake (ready only in IDLE)
//   cmd_write, cmd_addr, cmd_len      direction, byte start address, word count
//   wr_valid/wr_ready, wr_data        write-data stream (ready only in WAIT_W)
//   rd_valid/rd_ready, rd_data,
//   rd_last                           read-data stream, last marks final word
//   psel, penable, pwrite, paddr,
//   pwdata, prdata, pready, pslverr   APB initiator port
//   busy                              command in progress
//   done, err                         one-cycle completion / abort pulses
module tpum_apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [6:0]        cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT_W = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  // TIMEOUT-1 is the largest value the counter ever has to hold.
  localparam int TW = $clog2(TIMEOUT);

  logic [2:0]    state;
  logic [6:0]    remaining;
  logic [TW-1:0] tcnt;

  assign cmd_ready = (state == S_IDLE);
  assign wr_ready  = (state == S_WAIT_W);

  // paddr doubles as the running beat address; it simply holds in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      remaining <= '0;
      tcnt      <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            pwrite    <= cmd_write;
            paddr     <= cmd_addr & ~ADDR_W'(3);
            remaining <= cmd_len;
            if (cmd_len == 7'd0) begin
              done <= 1'b1;
            end else begin
              busy <= 1'b1;
              if (cmd_write) begin
                state <= S_WAIT_W;
              end else begin
                psel  <= 1'b1;
                state <= S_SETUP;
              end
            end
          end
        end

        S_WAIT_W: begin
          if (wr_valid) begin
            pwdata <= wr_data;
            psel   <= 1'b1;
            state  <= S_SETUP;
          end
        end

        S_SETUP: begin
          penable <= 1'b1;
          tcnt    <= '0;
          state   <= S_ACCESS;
        end

        S_ACCESS: begin
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            if (pslverr) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else if (pwrite) begin
              remaining <= remaining - 7'd1;
              paddr     <= paddr + ADDR_W'(4);
              if (remaining == 7'd1) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_IDLE;
              end else begin
                state <= S_WAIT_W;
              end
            end else begin
              rd_data  <= prdata;
              rd_valid <= 1'b1;
              rd_last  <= (remaining == 7'd1);
              state    <= S_RESP;
            end
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            // pready has priority above, so this only fires on a real stall
            psel    <= 1'b0;
            penable <= 1'b0;
            err     <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        S_RESP: begin
          if (rd_ready) begin
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            remaining <= remaining - 7'd1;
            paddr     <= paddr + ADDR_W'(4);
            if (remaining == 7'd1) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              psel  <= 1'b1;
              state <= S_SETUP;
            end
          end
        end

        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpum_apb_master.sv
// Directed testbench for tpum_apb_master with a small APB slave model
// (configurable wait states, error injection, never-ready mode) backed by a
// 256-word memory.
module tb_tpum_apb_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [6:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;
  logic        busy, done, err;

  always #5 clk = ~clk;

  tpum_apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .busy(busy), .done(done), .err(err)
  );

  // ---------------- slave model and monitors ----------------
  int lat = 1;        // ACCESS cycles without pready before pready rises
  bit never = 1'b0;   // pready stuck low
  int err_beat = 0;   // 1-based transfer (since tr_base) that gets pslverr
  int tr_base = 0;

  int wcnt = 0, tr_cnt = 0, setup_cnt = 0, acc_cnt = 0, wr_hs = 0;
  int done_cnt = 0, err_cnt = 0, rdv_apb = 0;
  logic [31:0] mem [0:255];
  logic [31:0] wq  [0:63];
  logic [31:0] tr_addr[$];
  logic [31:0] tr_data[$];
  logic [31:0] rq_data[$];
  logic        rq_last[$];

  assign pready  = psel && penable && !never && (wcnt >= lat);
  assign pslverr = pready && (err_beat != 0) && (tr_cnt - tr_base + 1 == err_beat);
  assign prdata  = mem[paddr[9:2]];
  assign wr_data = wq[wr_hs[5:0]];

  always @(posedge clk) begin
    if (psel && penable && !pready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (psel && !penable) setup_cnt <= setup_cnt + 1;
    if (psel && penable) acc_cnt <= acc_cnt + 1;
    if (psel && penable && pready) begin
      tr_addr.push_back(paddr);
      tr_data.push_back(pwrite ? pwdata : prdata);
      if (pwrite && !pslverr) mem[paddr[9:2]] <= pwdata;
      tr_cnt <= tr_cnt + 1;
    end
    if (wr_valid && wr_ready) wr_hs <= wr_hs + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (rd_valid && rd_ready) begin
      rq_data.push_back(rd_data);
      rq_last.push_back(rd_last);
    end
    if (rd_valid && psel) rdv_apb <= rdv_apb + 1;
  end

  // rd_ready driver: hold a level or toggle every cycle
  bit rd_toggle = 1'b0;
  bit rd_hold   = 1'b0;
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rd_ready = rd_toggle ? ~rd_ready : rd_hold;
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  int b_tr, b_setup, b_acc, b_wr, b_done, b_err, b_rq, b_rdv;

  task automatic snap();
    b_tr = tr_cnt; b_setup = setup_cnt; b_acc = acc_cnt; b_wr = wr_hs;
    b_done = done_cnt; b_err = err_cnt; b_rq = rq_data.size(); b_rdv = rdv_apb;
    tr_base = tr_cnt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [6:0] l);
    check("cmd_ready_before_cmd", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    tick();
    // garbage while busy must be ignored
    cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = 32'hDEAD_BEE0; cmd_len = 7'd5;
  endtask

  task automatic wait_end(input string tag, output int cyc);
    cyc = 0;
    while (!(done || err) && cyc < 3000) begin
      tick();
      cyc++;
    end
    if (!(done || err)) check({tag, "_no_completion"}, 0, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int cyc;
  int found;

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0;
    for (int i = 0; i < 64; i++) wq[i] = '0;

    // ---- reset state ----
    repeat (3) tick();
    check("rst_psel", 32'(psel), 0);
    check("rst_penable", 32'(penable), 0);
    check("rst_pwrite", 32'(pwrite), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done_err", 32'({done, err}), 0);
    check("rst_rd_valid_last", 32'({rd_valid, rd_last}), 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_cmd_ready", 32'(cmd_ready), 1);
    check("post_rst_wr_ready", 32'(wr_ready), 0);

    // ---- single write 0x10 <- 1 ----
    snap();
    wq[6'(wr_hs)] = 32'd1;
    wr_valid = 1'b1;
    send_cmd(1'b1, 32'h10, 7'd1);
    check("w1_busy", 32'(busy), 1);
    wait_end("w1", cyc);
    check("w1_cycles", cyc, 4);
    check("w1_done_err", 32'({done, err}), 32'b10);
    check("w1_busy_end", 32'(busy), 0);
    wr_valid = 1'b0;
    tick();
    check("w1_done_pulse", 32'(done), 0);
    check("w1_transfers", tr_cnt - b_tr, 1);
    check("w1_setups", setup_cnt - b_setup, 1);
    check("w1_paddr", tr_addr[b_tr], 32'h10);
    check("w1_pwdata", tr_data[b_tr], 1);

    // ---- single read-back, low address bits ignored ----
    rd_hold = 1'b1;
    tick();
    snap();
    send_cmd(1'b0, 32'h13, 7'd1);
    wait_end("r1", cyc);
    check("r1_cycles", cyc, 4);
    tick();
    check("r1_count", rq_data.size() - b_rq, 1);
    check("r1_data", rq_data[b_rq], 1);
    check("r1_last", 32'(rq_last[b_rq]), 1);
    check("r1_paddr", tr_addr[b_tr], 32'h10);

    // ---- 32-word write burst at 0x40, data i*3 ----
    snap();
    for (int i = 0; i < 32; i++) wq[6'(wr_hs + i)] = 32'(i * 3);
    wr_valid = 1'b1;
    send_cmd(1'b1, 32'h40, 7'd32);
    wait_end("w32", cyc);
    check("w32_cycles", cyc, 128);
    wr_valid = 1'b0;
    tick();
    check("w32_wr_hs", wr_hs - b_wr, 32);
    check("w32_done_cnt", done_cnt - b_done, 1);
    check("w32_err_cnt", err_cnt - b_err, 0);
    for (int i = 0; i < 32; i++) check("w32_paddr", tr_addr[b_tr + i], 32'(32'h40 + 4 * i));

    // ---- 32-word read burst, rd_ready toggling ----
    snap();
    rd_toggle = 1'b1;
    send_cmd(1'b0, 32'h40, 7'd32);
    wait_end("r32", cyc);
    tick();
    rd_toggle = 1'b0;
    check("r32_count", rq_data.size() - b_rq, 32);
    for (int i = 0; i < 32; i++) begin
      check("r32_data", rq_data[b_rq + i], 32'(i * 3));
      check("r32_last", 32'(rq_last[b_rq + i]), 32'(i == 31));
    end
    check("r32_apb_while_rd_valid", rdv_apb - b_rdv, 0);
    check("r32_done_cnt", done_cnt - b_done, 1);

    // ---- pready on the TIMEOUT-th ACCESS cycle still succeeds ----
    rd_hold = 1'b1;
    tick();
    lat = 7;
    snap();
    send_cmd(1'b0, 32'h44, 7'd1);
    wait_end("lat7", cyc);
    check("lat7_cycles", cyc, 10);
    check("lat7_done_err", 32'({done, err}), 32'b10);
    tick();
    check("lat7_access_cycles", acc_cnt - b_acc, 8);
    check("lat7_data", rq_data[b_rq], 3);
    lat = 1;

    // ---- timeout abort ----
    never = 1'b1;
    snap();
    send_cmd(1'b0, 32'h0, 7'd2);
    wait_end("tmo", cyc);
    check("tmo_cycles", cyc, 9);
    check("tmo_done_err", 32'({done, err}), 32'b01);
    check("tmo_psel_penable", 32'({psel, penable}), 0);
    check("tmo_busy", 32'(busy), 0);
    tick();
    check("tmo_access_cycles", acc_cnt - b_acc, 8);
    check("tmo_transfers", tr_cnt - b_tr, 0);
    check("tmo_rd_words", rq_data.size() - b_rq, 0);
    check("tmo_err_cnt", err_cnt - b_err, 1);
    never = 1'b0;
    send_cmd(1'b0, 32'h0, 7'd0);
    check("tmo_next_cmd_done", 32'(done), 1);

    // ---- pslverr on beat 3 of 5 ----
    tick();
    snap();
    for (int i = 0; i < 5; i++) wq[6'(wr_hs + i)] = 32'(32'hA0 + i);
    err_beat = 3;
    wr_valid = 1'b1;
    send_cmd(1'b1, 32'h80, 7'd5);
    wait_end("slv", cyc);
    check("slv_done_err", 32'({done, err}), 32'b01);
    check("slv_busy", 32'(busy), 0);
    wr_valid = 1'b0;
    tick();
    err_beat = 0;
    check("slv_transfers", tr_cnt - b_tr, 3);
    check("slv_setups", setup_cnt - b_setup, 3);
    check("slv_wr_hs", wr_hs - b_wr, 3);
    check("slv_done_cnt", done_cnt - b_done, 0);
    check("slv_paddr3", tr_addr[b_tr + 2], 32'h88);

    // ---- reset during ACCESS of beat 2 ----
    snap();
    for (int i = 0; i < 4; i++) wq[6'(wr_hs + i)] = 32'(32'h500 + i);
    wr_valid = 1'b1;
    send_cmd(1'b1, 32'h200, 7'd4);
    found = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (psel && penable && (tr_cnt - b_tr == 1)) begin
        found = 1;
        break;
      end
    end
    check("rstmid_reached_beat2", found, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_psel_penable", 32'({psel, penable}), 0);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_paddr", paddr, 0);
    wr_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("rstmid_done_err_cnt", (done_cnt - b_done) + (err_cnt - b_err), 0);
    check("rstmid_transfers", tr_cnt - b_tr, 1);
    snap();
    send_cmd(1'b0, 32'h300, 7'd0);
    check("len0_done", 32'(done), 1);
    check("len0_busy", 32'(busy), 0);
    tick();
    check("len0_done_pulse", 32'(done), 0);
    check("len0_no_apb", setup_cnt - b_setup, 0);
    check("len0_done_cnt", done_cnt - b_done, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
